sys_mem_param: RTL and testbench

Parametrised word-organised scratch memory with byte-lane (sub-word) and full-word access, a request/acknowledge handshake, and a clear operation. It serves as the system data store between the controller datapath and the register file. Default parameters give 16 words of 4×8-bit lanes, i.e. 64 byte addresses.

---
 rtl/sys_mem_param_if.sv | 22 ++
 rtl/sys_mem_param.sv | 158 +++++++++++++++
 tb/tb_sys_mem_param.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sys_mem_param_if.sv
// rtl/sys_mem_param_if.sv - request/ack access bus for the parametrised scratch memory
interface sys_mem_param_if #(
  parameter int LANE_W     = 8,
  parameter int LANE_SEL_W = 2,
  parameter int WORD_SEL_W = 4
);
  localparam int DW     = LANE_W * (2 ** LANE_SEL_W);
  localparam int ADRS_W = WORD_SEL_W + LANE_SEL_W;

  logic              req;
  logic              mode;
  logic              size;
  logic [ADRS_W-1:0] adrs;
  logic [DW-1:0]     data;
  logic              erase;
  logic [DW-1:0]     out;
  logic              ack;
  logic              busy;

  modport master (output req, mode, size, adrs, data, erase, input out, ack, busy);
  modport slave  (input req, mode, size, adrs, data, erase, output out, ack, busy);
endinterface

// File: rtl/sys_mem_param.sv
// rtl/sys_mem_param.sv - word/lane scratch memory with req/ack handshake and erase
// Optional SYS_MEM_ERASE_SWEEP_EN: erase clears one word per cycle in an ERASE state.
module sys_mem_param #(
  parameter int LANE_W     = 8,
  parameter int LANE_SEL_W = 2,
  parameter int WORD_SEL_W = 4,
  parameter logic [LANE_W*(2**LANE_SEL_W)-1:0] INIT_W0 = 32'h0309_0607
) (
  input logic          clk,
  input logic          rst,
  sys_mem_param_if.slave bus
);
  localparam int LANES  = 2 ** LANE_SEL_W;
  localparam int DW     = LANE_W * LANES;
  localparam int WORDS  = 2 ** WORD_SEL_W;
  localparam int ADRS_W = WORD_SEL_W + LANE_SEL_W;

  typedef enum logic [2:0] {IDLE, FETCH, MERGE, COMMIT, ERASE} state_t;

  state_t state, next;

  logic [DW-1:0]         mem [WORDS];
  logic [DW-1:0]         temp;
  logic [DW-1:0]         out_r;
  logic                  ack_r;
  logic                  l_mode;
  logic                  l_size;
  logic [ADRS_W-1:0]     l_adrs;
  logic [DW-1:0]         l_data;
  logic [WORD_SEL_W-1:0] l_word;
  logic [LANE_SEL_W-1:0] l_lane;
  logic [LANE_W-1:0]     rd_lane;

  logic ld_req, ld_temp, do_merge, commit_rd, commit_wr, clear_all, ack_set;
`ifdef SYS_MEM_ERASE_SWEEP_EN
  logic                  sweep_we;
  logic [WORD_SEL_W-1:0] sweep_idx;
`endif

  assign l_word  = l_adrs[ADRS_W-1:LANE_SEL_W];
  assign l_lane  = l_adrs[LANE_SEL_W-1:0];
  assign rd_lane = temp[l_lane*LANE_W +: LANE_W];

  assign bus.out  = out_r;
  assign bus.ack  = ack_r;
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next      = state;
    ld_req    = 1'b0;
    ld_temp   = 1'b0;
    do_merge  = 1'b0;
    commit_rd = 1'b0;
    commit_wr = 1'b0;
    clear_all = 1'b0;
    ack_set   = 1'b0;
`ifdef SYS_MEM_ERASE_SWEEP_EN
    sweep_we  = 1'b0;
`endif
    case (state)
      IDLE: begin
        // erase takes priority over a request raised in the same cycle
        if (bus.erase) begin
`ifdef SYS_MEM_ERASE_SWEEP_EN
          next = ERASE;
`else
          clear_all = 1'b1;
          ack_set   = 1'b1;
`endif
        end else if (bus.req) begin
          ld_req = 1'b1;
          next   = FETCH;
        end
      end
      FETCH: begin
        ld_temp = 1'b1;
        next    = l_mode ? MERGE : COMMIT;
      end
      MERGE: begin
        do_merge = 1'b1;
        next     = COMMIT;
      end
      COMMIT: begin
        commit_rd = ~l_mode;
        commit_wr = l_mode;
        ack_set   = 1'b1;
        next      = IDLE;
      end
      ERASE: begin
`ifdef SYS_MEM_ERASE_SWEEP_EN
        sweep_we = 1'b1;
        if (sweep_idx == {WORD_SEL_W{1'b1}}) begin
          ack_set = 1'b1;
          next    = IDLE;
        end
`else
        next = IDLE;
`endif
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      temp   <= '0;
      out_r  <= '0;
      ack_r  <= 1'b0;
      l_mode <= 1'b0;
      l_size <= 1'b0;
      l_adrs <= '0;
      l_data <= '0;
    end else begin
      ack_r <= ack_set;
      if (ld_req) begin
        l_mode <= bus.mode;
        l_size <= bus.size;
        l_adrs <= bus.adrs;
        l_data <= bus.data;
      end
      if (ld_temp) temp <= mem[l_word];
      if (do_merge) begin
        if (l_size) temp <= l_data;
        else        temp[l_lane*LANE_W +: LANE_W] <= l_data[LANE_W-1:0];
      end
      if (commit_rd) begin
        if (l_size) out_r <= temp;
        else        out_r <= {{(DW-LANE_W){1'b0}}, rd_lane};
      end
    end
  end

`ifdef SYS_MEM_ERASE_SWEEP_EN
  always_ff @(posedge clk) begin
    if (rst)           sweep_idx <= '0;
    else if (sweep_we) sweep_idx <= sweep_idx + 1'b1;
  end
`endif

  // reset restores the power-on image: INIT_W0 in word 0, zero elsewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      mem[0] <= INIT_W0;
    end else begin
      if (commit_wr) mem[l_word] <= temp;
      if (clear_all) for (int i = 0; i < WORDS; i++) mem[i] <= '0;
`ifdef SYS_MEM_ERASE_SWEEP_EN
      if (sweep_we) mem[sweep_idx] <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_sys_mem_param.sv
// tb/tb_sys_mem_param.sv - directed self-checking bench for sys_mem_param
module tb_sys_mem_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sys_mem_param_if bus ();

  sys_mem_param dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // issues one access and returns the number of edges from accept to ack (99 on timeout)
  task automatic access(input logic m, input logic s, input logic [5:0] a,
                        input logic [31:0] d, output int lat);
    @(negedge clk);
    bus.req = 1'b1; bus.mode = m; bus.size = s; bus.adrs = a; bus.data = d;
    @(posedge clk); #1;
    bus.req = 1'b0;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.ack) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int acks;
  int first_ack;
  int busy_cnt;
  logic [7:0] exp_lane [4];

  initial begin
    bus.req = 1'b0; bus.mode = 1'b0; bus.size = 1'b0;
    bus.adrs = '0; bus.data = '0; bus.erase = 1'b0;
    exp_lane[0] = 8'h07; exp_lane[1] = 8'h06; exp_lane[2] = 8'h09; exp_lane[3] = 8'h03;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out", bus.out, 32'h0);
    chk("reset_ack", {31'b0, bus.ack}, 32'd0);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      access(1'b0, 1'b0, 6'(i), 32'h0, lat);
      chk($sformatf("init_lane%0d", i), bus.out, {24'h0, exp_lane[i]});
      chk($sformatf("init_lane%0d_lat", i), lat, 2);
    end

    access(1'b1, 1'b0, 6'd6, 32'hFFFF_FFA5, lat);
    chk("lane_wr_lat", lat, 3);
    chk("lane_wr_out_hold", bus.out, 32'h0000_0003);
    access(1'b0, 1'b1, 6'd4, 32'h0, lat);
    chk("word_rd_adrs4", bus.out, 32'h00A5_0000);
    chk("word_rd_lat", lat, 2);

    // word write with a stray request raised while busy
    @(negedge clk);
    bus.req = 1'b1; bus.mode = 1'b1; bus.size = 1'b1; bus.adrs = 6'd60; bus.data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    bus.mode = 1'b0; bus.data = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    acks = 0; first_ack = 0;
    for (int i = 3; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.ack) begin
        acks++;
        if (first_ack == 0) first_ack = i;
      end
    end
    chk("word_wr_acks", acks, 1);
    chk("word_wr_ack_edge", first_ack, 3);
    chk("word_wr_out_hold", bus.out, 32'h00A5_0000);

    access(1'b0, 1'b0, 6'd61, 32'h0, lat);
    chk("lane_rd_adrs61", bus.out, 32'h0000_00BE);
    access(1'b0, 1'b1, 6'd63, 32'h0, lat);
    chk("word_rd_ignore_lane", bus.out, 32'hDEAD_BEEF);

    // erase and req together: erase must win
    @(negedge clk);
    bus.erase = 1'b1; bus.req = 1'b1; bus.mode = 1'b1; bus.size = 1'b1;
    bus.adrs = 6'd0; bus.data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.erase = 1'b0; bus.req = 1'b0;
`ifdef SYS_MEM_ERASE_SWEEP_EN
    busy_cnt = 0; acks = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ack) begin
        acks = 1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
    end
    chk("erase_busy_cycles", busy_cnt, 16);
    chk("erase_ack", acks, 1);
    chk("erase_busy_at_ack", {31'b0, bus.busy}, 32'd0);
`else
    busy_cnt = 0;
    chk("erase_ack", {31'b0, bus.ack}, 32'd1);
    chk("erase_busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    chk("erase_ack_pulse", {31'b0, bus.ack}, 32'd0);
`endif
    access(1'b0, 1'b1, 6'd0, 32'h0, lat);
    chk("erase_word0", bus.out, 32'h0);
    access(1'b0, 1'b1, 6'd60, 32'h0, lat);
    chk("erase_word15", bus.out, 32'h0);

    // reset during MERGE aborts the write
    @(negedge clk);
    bus.req = 1'b1; bus.mode = 1'b1; bus.size = 1'b0; bus.adrs = 6'd8; bus.data = 32'h0000_00FF;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ack) acks++;
      @(posedge clk); #1;
    end
    chk("abort_no_ack", acks, 0);
    access(1'b0, 1'b0, 6'd8, 32'h0, lat);
    chk("abort_adrs8", bus.out, 32'h0);
    access(1'b0, 1'b0, 6'd0, 32'h0, lat);
    chk("abort_adrs0", bus.out, 32'h0000_0007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
